// File: rtl/operand_loader.sv
// operand_loader: loads two operands into the core's R1/R2, runs it frozen-free,
// and hands the captured result downstream over a valid/ready port.
module operand_loader #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             wr_R1,
  output logic             wr_R2,
  output logic [WIDTH-1:0] wr_data,
  output logic             core_rst,
  output logic             E,
  input  logic             LD_outr,
  input  logic [WIDTH-1:0] outr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LOAD_B, ARM, RUN, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_wr_r1, r_wr_r2, r_core_rst, r_e, r_res_valid, r_err;
  logic w_wr_r1_nx, w_wr_r2_nx, w_core_rst_nx, w_e_nx, w_res_valid_nx, w_err_nx;
  logic [WIDTH-1:0] r_wr_data, r_res_data, w_wr_data_nx, w_res_data_nx;
  logic w_hs;
  assign in_ready  = (r_state == IDLE) || (r_state == LOAD_B);
  assign busy      = r_state != IDLE;
  assign w_hs      = in_valid & in_ready;
  assign wr_R1     = r_wr_r1;
  assign wr_R2     = r_wr_r2;
  assign wr_data   = r_wr_data;
  assign core_rst  = r_core_rst;
  assign E         = r_e;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign err       = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_wr_r1_nx     = 1'b0;
    w_wr_r2_nx     = 1'b0;
    w_wr_data_nx   = r_wr_data;
    w_core_rst_nx  = r_core_rst;
    w_e_nx         = r_e;
    w_res_valid_nx = r_res_valid;
    w_res_data_nx  = r_res_data;
    w_err_nx       = r_err;
    case (r_state)
      IDLE: begin
        w_e_nx        = 1'b1;
        w_core_rst_nx = 1'b1;
        if (w_hs) begin
          w_wr_data_nx = in_data;
          w_wr_r1_nx   = 1'b1;
          w_state_nx   = LOAD_B;
        end
      end
      LOAD_B: if (w_hs) begin
        w_wr_data_nx = in_data;
        w_wr_r2_nx   = 1'b1;
        w_state_nx   = ARM;
      end
      ARM: begin
        w_cnt_nx      = '0;
        w_e_nx        = 1'b0;
        w_core_rst_nx = 1'b0;
        w_state_nx    = RUN;
      end
      RUN: begin
        w_cnt_nx = r_cnt + 1'b1;
        // a result arriving on the timeout cycle still counts as success
        if (LD_outr) begin
          w_res_data_nx  = outr;
          w_res_valid_nx = 1'b1;
          w_e_nx         = 1'b1;
          w_state_nx     = DONE;
        end else if (r_cnt == LAST) begin
          w_err_nx      = 1'b1;
          w_e_nx        = 1'b1;
          w_core_rst_nx = 1'b1;
          w_state_nx    = IDLE;
        end
      end
      DONE: if (res_ready) begin
        w_res_valid_nx = 1'b0;
        w_core_rst_nx  = 1'b1;
        w_state_nx     = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt       <= '0;
      r_wr_r1     <= 1'b0;
      r_wr_r2     <= 1'b0;
      r_wr_data   <= '0;
      r_core_rst  <= 1'b1;
      r_e         <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_wr_r1     <= w_wr_r1_nx;
      r_wr_r2     <= w_wr_r2_nx;
      r_wr_data   <= w_wr_data_nx;
      r_core_rst  <= w_core_rst_nx;
      r_e         <= w_e_nx;
      r_res_valid <= w_res_valid_nx;
      r_res_data  <= w_res_data_nx;
      r_err       <= w_err_nx;
    end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed scenario tasks for operand_loader with hand-computed expectations.
module tb_operand_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, LD_outr = 1'b0, res_ready = 1'b0;
  logic [3:0] in_data = '0, outr = '0;
  logic in_ready, wr_R1, wr_R2, core_rst, E, res_valid, busy, err;
  logic [3:0] wr_data, res_data;
  int pass_cnt = 0, total_cnt = 0;
  operand_loader #(.WIDTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_R1(wr_R1), .wr_R2(wr_R2), .wr_data(wr_data), .core_rst(core_rst), .E(E),
    .LD_outr(LD_outr), .outr(outr), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // two handshakes then the ARM cycle; returns in RUN cycle 0
  task automatic load(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    logic [16:0] got;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 4'h9;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({wr_R1, busy} !== 2'b11) $display("FAIL pre_reset_load: got %b want 11", {wr_R1, busy});
    else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    got = {in_ready, wr_R1, wr_R2, wr_data, core_rst, E, res_valid, res_data, busy, err};
    total_cnt++;
    if (got !== 17'b1_0_0_0000_1_1_0_0000_0_0) $display("FAIL async_reset_values: got %b want 10000001100000000", got);
    else pass_cnt++;
    #1 rst = 1'b0;
    tick();
    total_cnt++;
    if ({in_ready, E, busy} !== 3'b110) $display("FAIL after_release: got %b want 110", {in_ready, E, busy});
    else pass_cnt++;
  endtask
  task automatic test_basic;
    in_valid = 1'b1;
    in_data  = 4'd3;
    tick();
    total_cnt++;
    if ({wr_R1, wr_R2, wr_data, in_ready} !== {2'b10, 4'd3, 1'b1}) $display("FAIL basic_wr_r1: got %b want 1000111", {wr_R1, wr_R2, wr_data, in_ready});
    else pass_cnt++;
    in_data = 4'd5;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({wr_R1, wr_R2, wr_data, in_ready, E, core_rst} !== {2'b01, 4'd5, 3'b011}) $display("FAIL basic_arm: got %b want 010101011", {wr_R1, wr_R2, wr_data, in_ready, E, core_rst});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({wr_R2, E, core_rst, busy} !== 4'b0001) $display("FAIL basic_run_entry: got %b want 0001", {wr_R2, E, core_rst, busy});
    else pass_cnt++;
    repeat (6) tick();
    total_cnt++;
    if ({res_valid, E} !== 2'b00) $display("FAIL basic_still_running: got %b want 00", {res_valid, E});
    else pass_cnt++;
    LD_outr = 1'b1;
    outr    = 4'd8;
    tick();
    LD_outr = 1'b0;
    outr    = 4'd0;
    total_cnt++;
    if ({res_valid, res_data, E, core_rst, busy} !== {1'b1, 4'd8, 3'b101}) $display("FAIL basic_capture: got %b want 11000101", {res_valid, res_data, E, core_rst, busy});
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({res_valid, in_ready, core_rst, busy, E, err} !== 6'b011010) $display("FAIL basic_return_idle: got %b want 011010", {res_valid, in_ready, core_rst, busy, E, err});
    else pass_cnt++;
  endtask
  task automatic test_backpressure;
    load(4'd3, 4'd5);
    repeat (2) tick();
    LD_outr = 1'b1;
    outr    = 4'd8;
    tick();
    LD_outr  = 1'b0;
    outr     = 4'd1;
    in_valid = 1'b1;
    in_data  = 4'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({res_valid, res_data, in_ready, E, wr_R1, wr_R2} !== {1'b1, 4'd8, 4'b0100}) $display("FAIL backpressure_hold[%0d]: got %b want 110000100", i, {res_valid, res_data, in_ready, E, wr_R1, wr_R2});
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({res_valid, in_ready, wr_R1} !== 3'b010) $display("FAIL backpressure_release: got %b want 010", {res_valid, in_ready, wr_R1});
    else pass_cnt++;
  endtask
  task automatic test_timeout;
    load(4'd1, 4'd2);
    repeat (15) tick();
    total_cnt++;
    if ({busy, err, E} !== 3'b100) $display("FAIL timeout_last_run_cycle: got %b want 100", {busy, err, E});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({err, E, core_rst, busy, res_valid, in_ready} !== 6'b111001) $display("FAIL timeout_abort: got %b want 111001", {err, E, core_rst, busy, res_valid, in_ready});
    else pass_cnt++;
    load(4'd3, 4'd5);
    tick();
    LD_outr = 1'b1;
    outr    = 4'd8;
    tick();
    LD_outr = 1'b0;
    total_cnt++;
    if ({res_valid, res_data, err} !== {1'b1, 4'd8, 1'b1}) $display("FAIL timeout_err_sticky_run: got %b want 110001", {res_valid, res_data, err});
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({err, busy} !== 2'b10) $display("FAIL timeout_err_sticky_idle: got %b want 10", {err, busy});
    else pass_cnt++;
  endtask
  task automatic test_simultaneous;
    rst = 1'b1;
    #2 rst = 1'b0;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL simul_err_cleared: got %b want 0", err);
    else pass_cnt++;
    tick();
    load(4'd6, 4'd9);
    repeat (15) tick();
    LD_outr = 1'b1;
    outr    = 4'hF;
    tick();
    LD_outr = 1'b0;
    outr    = 4'h0;
    total_cnt++;
    if ({res_valid, res_data, err, busy, E} !== {1'b1, 4'hF, 3'b011}) $display("FAIL simul_capture: got %b want 11111011", {res_valid, res_data, err, busy, E});
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({busy, err} !== 2'b00) $display("FAIL simul_idle: got %b want 00", {busy, err});
    else pass_cnt++;
  endtask
  task automatic test_reset_midop;
    load(4'd2, 4'd4);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({res_valid, busy, core_rst, E, in_ready} !== 5'b00111) $display("FAIL rst_in_run: got %b want 00111", {res_valid, busy, core_rst, E, in_ready});
    else pass_cnt++;
    #1 rst = 1'b0;
    tick();
    load(4'd1, 4'd1);
    tick();
    LD_outr = 1'b1;
    outr    = 4'hA;
    tick();
    LD_outr = 1'b0;
    total_cnt++;
    if ({res_valid, res_data} !== 5'b11010) $display("FAIL rst_done_setup: got %b want 11010", {res_valid, res_data});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({res_valid, res_data, busy, core_rst} !== 7'b0000001) $display("FAIL rst_in_done: got %b want 0000001", {res_valid, res_data, busy, core_rst});
    else pass_cnt++;
    #1 rst = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 4'd2;
    tick();
    total_cnt++;
    if ({wr_R1, wr_data} !== 5'b10010) $display("FAIL reload_r1: got %b want 10010", {wr_R1, wr_data});
    else pass_cnt++;
    in_data = 4'd4;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if ({wr_R2, wr_data} !== 5'b10100) $display("FAIL reload_r2: got %b want 10100", {wr_R2, wr_data});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({E, core_rst} !== 2'b00) $display("FAIL reload_run: got %b want 00", {E, core_rst});
    else pass_cnt++;
    tick();
    LD_outr = 1'b1;
    outr    = 4'd6;
    tick();
    LD_outr = 1'b0;
    total_cnt++;
    if ({res_valid, res_data} !== 5'b10110) $display("FAIL reload_result: got %b want 10110", {res_valid, res_data});
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({busy, res_valid, err} !== 3'b000) $display("FAIL reload_idle: got %b want 000", {busy, res_valid, err});
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end sequencer that feeds the `main` control/datapath core. It accepts two operands over a valid/ready stream and writes them into R1 and R2 through explicit write strobes. It holds the core frozen (`E`) and in reset while loading, then releases it. When the core pulses `LD_outr`, it captures `outr` and presents the result on a valid/ready output, so the core is driven entirely through ports rather than by poking registers from the bench.

## Interface
- WIDTH, 4, operand/result width; matches the datapath register width.
- TIMEOUT, 16, maximum RUN cycles allowed before `LD_outr` must be seen; must be ≥2.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand word available.
- in_ready  output  1  loader can accept an operand this cycle.
- in_data  input  WIDTH  operand (first word → R1, second → R2).
- wr_R1  output  1  one-cycle write strobe to datapath R1.
- wr_R2  output  1  one-cycle write strobe to datapath R2.
- wr_data  output  WIDTH  data for wr_R1/wr_R2, valid while either strobe is high.
- core_rst  output  1  reset to the core, active-high, registered.
- E  output  1  core freeze; 1 = frozen.
- LD_outr  input  1  core's output-register load (result ready).
- outr  input  WIDTH  core result, sampled when LD_outr=1.
- res_valid  output  1  result held on res_data.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  captured result.
- busy  output  1  state ≠ IDLE.
- err  output  1  sticky timeout flag.

## Operation
- States: IDLE, LOAD_B, ARM, RUN, DONE. Reset → IDLE.
- `in_ready` is a combinational decode: 1 in IDLE and LOAD_B, else 0. A handshake is `in_valid & in_ready`.
- **IDLE:** E=1, core_rst=1. On handshake: register wr_data=in_data, wr_R1=1 next cycle, go to LOAD_B.
- **LOAD_B:** E=1, core_rst=1. On handshake: register wr_data=in_data, wr_R2=1 next cycle, go to ARM.
- **ARM:** exactly one cycle. Behaviour:
  - wr_R2 is high in this cycle; E=1, core_rst=1.
  - Next state is RUN, with core_rst=0 and E=0 registered on the transition.
  - The run counter clears to 0.
- **RUN:** E=0, core_rst=0; the counter increments every cycle.
  - LD_outr=1: res_data←outr, res_valid←1, E←1, go to DONE.
  - Otherwise, when counter = TIMEOUT-1: err←1, E←1, core_rst←1, go to IDLE. No result is produced.
  - If LD_outr arrives in the same cycle as the timeout, LD_outr wins: capture, no err.
- **DONE:** E=1, core_rst=0 (the core holds its state); res_valid=1, res_data stable.
  - On `res_valid & res_ready`: res_valid←0, core_rst←1, go to IDLE.
- Strobes `wr_R1`/`wr_R2` are registered, one cycle wide, never high together. `wr_data` holds its last value otherwise.
- `err` clears only on rst.
- `busy` = (state ≠ IDLE).
- Counter width is clog2(TIMEOUT). No wrap is possible because the counter exits at TIMEOUT-1.

## Timing
- Reset values: state=IDLE, in_ready=1, wr_R1=0, wr_R2=0, wr_data=0, core_rst=1, E=1, res_valid=0, res_data=0, busy=0, err=0.
- Reset is asynchronous at any point, including mid-RUN or in DONE. It returns all outputs to their reset values immediately, and any pending result is discarded.
- Handshake at edge n (first operand): wr_R1=1 during cycle n+1.
- Second handshake at edge m: wr_R2=1 during cycle m+1 (ARM); E=0 and core_rst=0 from cycle m+2.
- Back-to-back operands are supported: the LOAD_B handshake may occur in the same cycle that wr_R1 is high.
- LD_outr sampled at edge k: res_valid=1 and E=1 from cycle k+1.
- Result handshake at edge r: res_valid=0 and in_ready=1 from cycle r+1. The minimum turnaround is one cycle.
- in_valid is ignored in ARM, RUN and DONE (in_ready=0); the upstream holds its data.
- res_data changes only on capture, so it is stable while res_valid=1 regardless of res_ready.

## Test plan
- **Reset state:** assert rst mid-cycle → all outputs take their reset values asynchronously; release → in_ready=1, E=1.
- **Basic run:** send 3 then 5 with in_valid held high.
  - Expect: wr_R1 with wr_data=3, then wr_R2 with wr_data=5 on the next cycle, E=0 two cycles later.
  - Core model pulses LD_outr with outr=8 after 6 RUN cycles → res_valid=1, res_data=8, E=1.
  - res_ready=1 → IDLE.
- **Backpressure:** hold res_ready=0 for 10 cycles in DONE → res_valid stays 1, res_data=8, in_ready=0, E=1.
  - Assert in_valid=1 with in_data=7 throughout → no wr strobe.
- **Timeout:** never pulse LD_outr, TIMEOUT=16 → after 16 RUN cycles err=1, E=1, core_rst=1, state IDLE, res_valid=0.
  - err stays 1 through a subsequent successful run.
- **Simultaneous:** LD_outr=1 with outr=0xF on the cycle the counter equals 15 → capture 0xF, err stays 0.
- **Reset mid-op:** assert rst in RUN, and separately in DONE → res_valid=0, busy=0, core_rst=1.
  - Reload 2 and 4 → normal sequence resumes.
